io_port_bank: RTL and testbench
===============================

# io_port_bank

Parametrised multi-port I/O controller serving the processor's IN/OUT instructions and external interrupts. It is the successor to the single-port I/O controller. It adds:
- selectable input/output ports of configurable width
- per-port write strobes
- error reporting for illegal accesses
- a multi-line interrupt front end with synchronisers, per-line pending latches, masking, fixed priority and acknowledge

It sits between the execute/memory stage control and the chip's external pins.

## Interface
- DATA_W, 8, width of each data port
- NUM_IN, 4, number of input ports (1..16)
- NUM_OUT, 4, number of output ports (1..16)
- NUM_IRQ, 4, number of interrupt lines (1..16)
- SYNC_STAGES, 2, synchroniser depth per interrupt line (≥2)
- PSEL_W, 4 (derived), port-select width, enough to index max(NUM_IN, NUM_OUT)
- IRQ_W, 4 (derived), interrupt-id width, enough to index NUM_IRQ
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- io_read  in  1  IN request; sampled only when io_ready=1
- io_write  in  1  OUT request; sampled only when io_ready=1
- port_sel  in  PSEL_W  port index for the request
- write_data  in  DATA_W  OUT data
- read_data  out  DATA_W  registered IN data; holds until the next read
- rd_valid  out  1  one-cycle pulse when read_data is updated
- in_ports  in  NUM_IN*DATA_W  input pins; port i = bits [i*DATA_W +: DATA_W]
- out_ports  out  NUM_OUT*DATA_W  registered output pins, same packing
- out_strobe  out  NUM_OUT  one-cycle pulse on the written port
- port_err  out  1  one-cycle pulse on an illegal request
- io_busy  out  1  access in progress
- io_ready  out  1  controller can accept a request
- intr_in  in  NUM_IRQ  asynchronous interrupt request lines
- irq_mask  in  NUM_IRQ  1 = line masked from intr_signal
- intr_ack  in  1  clears the pending bit of the current intr_id
- intr_signal  out  1  any unmasked pending line
- intr_id  out  IRQ_W  lowest-index unmasked pending line; 0 when none
- irq_pending  out  NUM_IRQ  raw pending latches, including masked lines

## Operation
- The access FSM has two states, IDLE and BUSY.
  - io_ready = (state==IDLE).
  - io_busy = (state==BUSY).
- In IDLE, a request moves the FSM to BUSY at the same clock edge. BUSY always returns to IDLE on the next edge.
- Requests seen while in BUSY are ignored. They are neither queued nor flagged.
- Legal read (port_sel < NUM_IN):
  - read_data ← in_ports[port_sel] at the acceptance edge.
  - rd_valid=1 for the following cycle.
- Legal write (port_sel < NUM_OUT):
  - out_ports[port_sel] ← write_data at the acceptance edge.
  - out_strobe[port_sel]=1 for the following cycle.
  - All other output ports hold their values.
- Out-of-range port_sel:
  - A read gives read_data ← 0 with rd_valid=1.
  - A write has no effect on out_ports or out_strobe.
  - In both cases port_err pulses and the FSM still enters BUSY.
- io_read and io_write asserted together: the read is performed, the write is dropped, and port_err pulses.
- Interrupt front end, per line:
  - SYNC_STAGES flip-flop synchroniser, then a previous-value register for edge detection.
  - A rising edge sets pending[i]. Masked lines still latch pending.
- intr_signal = |(irq_pending & ~irq_mask). intr_id is a fixed-priority encode in which index 0 is highest. Both are combinational from the registers.
- intr_ack with intr_signal=1 clears pending[intr_id]. intr_ack with intr_signal=0 has no effect.
- If a new edge on the same line arrives in the same cycle as its acknowledge, the set wins and pending stays 1.
- A level held high produces one pending set only. A new set requires a low→high transition.

## Timing
- Reset values:
  - read_data=0, out_ports=0, irq_pending=0, all synchroniser and edge registers 0.
  - rd_valid=0, out_strobe=0, port_err=0, io_busy=0, io_ready=1.
  - intr_signal=0, intr_id=0.
- Reset asserted mid-access forces IDLE at the next edge. Any pulse due in that cycle is suppressed.
- Access latency:
  - Request accepted at edge N; rd_valid, out_strobe and port_err are high between edge N and edge N+1; io_ready returns at edge N+1.
  - Sustained throughput is one access per 2 cycles.
- Interrupt latency: intr_in high at sampling edge E gives pending=1 after edge E+SYNC_STAGES, so intr_signal rises one SYNC_STAGES+1 cycles after the line goes high.
- intr_ack at edge A: pending clears after A, and intr_id/intr_signal update in the same cycle.
- Mask changes affect intr_signal and intr_id combinationally, in the same cycle.

## Test plan
- After reset: io_ready=1, out_ports=0, intr_signal=0. Then in_ports[2]=0xA5, io_read with port_sel=2 → read_data=0xA5 with one rd_valid pulse, io_busy high for 1 cycle.
- io_write with port_sel=3 and write_data=0x3C, then an immediate second io_write to port 1 during BUSY → out_ports[3]=0x3C with out_strobe=4'b1000; port 1 stays 0; the second request is ignored.
- io_read and io_write together with port_sel=1 → read performed, port_err pulses, out_ports unchanged. A write with port_sel=7 (NUM_OUT=4) → port_err, no strobe.
- Rising edges on intr_in[3] and intr_in[1] → intr_id=1. Ack → intr_id=3. Ack → intr_signal=0 and irq_pending=0.
- irq_mask[0]=1 and an edge on line 0 → irq_pending[0]=1, intr_signal=0. Clear the mask → intr_signal=1, intr_id=0 in the same cycle.
- Ack of line 2 in the same cycle as a new edge on line 2 → pending[2] stays 1. Assert reset mid-BUSY → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/io_port_bank.sv
// Multi-port IN/OUT controller with a synchronised, maskable, fixed-priority interrupt front end.
// One access per two cycles; requests arriving while BUSY are dropped.
module io_port_bank #(
  parameter int DATA_W      = 8,
  parameter int NUM_IN      = 4,
  parameter int NUM_OUT     = 4,
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PSEL_W      = 4,
  parameter int IRQ_W       = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_io_read,
  input  logic                      i_io_write,
  input  logic [PSEL_W-1:0]         i_port_sel,
  input  logic [DATA_W-1:0]         i_write_data,
  output logic [DATA_W-1:0]         o_read_data,
  output logic                      o_rd_valid,
  input  logic [NUM_IN*DATA_W-1:0]  i_in_ports,
  output logic [NUM_OUT*DATA_W-1:0] o_out_ports,
  output logic [NUM_OUT-1:0]        o_out_strobe,
  output logic                      o_port_err,
  output logic                      o_io_busy,
  output logic                      o_io_ready,
  input  logic [NUM_IRQ-1:0]        i_intr_in,
  input  logic [NUM_IRQ-1:0]        i_irq_mask,
  input  logic                      i_intr_ack,
  output logic                      o_intr_signal,
  output logic [IRQ_W-1:0]          o_intr_id,
  output logic [NUM_IRQ-1:0]        o_irq_pending
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_accept;
  logic                       w_rd_legal;
  logic                       w_wr_legal;
  logic [DATA_W-1:0]          w_rd_mux;

  logic [DATA_W-1:0]          r_read_data;
  logic                       r_rd_valid;
  logic [NUM_OUT*DATA_W-1:0]  r_out_ports;
  logic [NUM_OUT-1:0]         r_out_strobe;
  logic                       r_port_err;

  logic [NUM_IRQ-1:0]         r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0]         r_prev;
  logic [NUM_IRQ-1:0]         r_pending;
  logic [NUM_IRQ-1:0]         w_rise;
  logic [NUM_IRQ-1:0]         w_active;
  logic [NUM_IRQ-1:0]         w_first;
  logic [NUM_IRQ-1:0]         w_clr;
  logic [IRQ_W-1:0]           w_id;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_io_ready  = 1'b0;
    o_io_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_io_ready = 1'b1;
        if (i_io_read || i_io_write) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        o_io_busy   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_legal = int'(i_port_sel) < NUM_IN;
  assign w_wr_legal = int'(i_port_sel) < NUM_OUT;

  // Mux yields zero for an out-of-range select, which is exactly the illegal-read result.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(i_port_sel) == i) w_rd_mux = i_in_ports[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_read_data  <= '0;
      r_rd_valid   <= 1'b0;
      r_out_ports  <= '0;
      r_out_strobe <= '0;
      r_port_err   <= 1'b0;
    end else begin
      r_rd_valid   <= 1'b0;
      r_out_strobe <= '0;
      r_port_err   <= 1'b0;
      if (w_accept) begin
        if (i_io_read) begin
          // A simultaneous write is dropped in favour of the read and flagged.
          r_read_data <= w_rd_mux;
          r_rd_valid  <= 1'b1;
          r_port_err  <= !w_rd_legal || i_io_write;
        end else if (w_wr_legal) begin
          for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(i_port_sel) == i) begin
              r_out_ports[i*DATA_W +: DATA_W] <= i_write_data;
              r_out_strobe[i]                 <= 1'b1;
            end
          end
        end else begin
          r_port_err <= 1'b1;
        end
      end
    end
  end

  assign o_read_data  = r_read_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_out_ports  = r_out_ports;
  assign o_out_strobe = r_out_strobe;
  assign o_port_err   = r_port_err;

  assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_active = r_pending & ~i_irq_mask;

  // Descending scan so the lowest active index is the last one written.
  always_comb begin
    w_id    = '0;
    w_first = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_id       = IRQ_W'(i);
        w_first    = '0;
        w_first[i] = 1'b1;
      end
    end
  end

  assign w_clr = i_intr_ack ? w_first : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_sync[0] <= i_intr_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev    <= r_sync[SYNC_STAGES-1];
      // A fresh edge outranks an acknowledge on the same line.
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  assign o_intr_signal = |w_active;
  assign o_intr_id     = w_id;
  assign o_irq_pending = r_pending;

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: cycle-level reference model checked every cycle, plus directed literal checks.
module tb_io_port_bank;
  localparam int DW = 8;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int NQ = 4;
  localparam int SS = 2;
  localparam int PW = 4;
  localparam int QW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            io_read, io_write;
  logic [PW-1:0]   port_sel;
  logic [DW-1:0]   write_data;
  logic [DW-1:0]   read_data;
  logic            rd_valid;
  logic [NI*DW-1:0] in_ports;
  logic [NO*DW-1:0] out_ports;
  logic [NO-1:0]   out_strobe;
  logic            port_err, io_busy, io_ready;
  logic [NQ-1:0]   intr_in, irq_mask;
  logic            intr_ack;
  logic            intr_signal;
  logic [QW-1:0]   intr_id;
  logic [NQ-1:0]   irq_pending;

  always #5 clk = ~clk;

  io_port_bank #(
    .DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .NUM_IRQ(NQ),
    .SYNC_STAGES(SS), .PSEL_W(PW), .IRQ_W(QW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_io_read(io_read), .i_io_write(io_write),
    .i_port_sel(port_sel), .i_write_data(write_data), .o_read_data(read_data),
    .o_rd_valid(rd_valid), .i_in_ports(in_ports), .o_out_ports(out_ports),
    .o_out_strobe(out_strobe), .o_port_err(port_err), .o_io_busy(io_busy),
    .o_io_ready(io_ready), .i_intr_in(intr_in), .i_irq_mask(irq_mask),
    .i_intr_ack(intr_ack), .o_intr_signal(intr_signal), .o_intr_id(intr_id),
    .o_irq_pending(irq_pending)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per rising edge.
  bit          m_started = 1'b0;
  bit          m_busy;
  logic [7:0]  m_rd;
  bit          m_rdv;
  logic [7:0]  m_out [NO];
  logic [3:0]  m_strobe;
  bit          m_err;
  logic [3:0]  m_pend;
  logic [3:0]  m_hist [SS+1];   // m_hist[k] = intr_in sampled k+1 edges ago
  int          m_sel, m_f;
  logic [3:0]  m_rise;

  function automatic int first_active(input logic [3:0] pend, input logic [3:0] mask);
    for (int i = 0; i < NQ; i++) if (pend[i] && !mask[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1'b1;
      m_busy = 0; m_rd = 0; m_rdv = 0; m_strobe = 0; m_err = 0; m_pend = 0;
      for (int i = 0; i < NO; i++) m_out[i] = 0;
      for (int k = 0; k <= SS; k++) m_hist[k] = 0;
    end else if (m_started) begin
      m_rdv = 0; m_strobe = 0; m_err = 0;
      if (m_busy) begin
        m_busy = 0;
      end else if (io_read || io_write) begin
        m_busy = 1;
        m_sel  = int'(port_sel);
        if (io_read) begin
          if (m_sel < NI) m_rd = in_ports[m_sel*DW +: DW];
          else            m_rd = 8'h00;
          m_rdv = 1;
          m_err = (m_sel >= NI) || io_write;
        end else if (m_sel < NO) begin
          m_out[m_sel]    = write_data;
          m_strobe[m_sel] = 1'b1;
        end else begin
          m_err = 1;
        end
      end
      m_f = first_active(m_pend, irq_mask);
      if (intr_ack && m_f >= 0) m_pend[m_f] = 1'b0;
      m_rise = m_hist[SS-1] & ~m_hist[SS];
      m_pend = m_pend | m_rise;
      for (int k = SS; k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = intr_in;
    end
  end

  logic [31:0] exp_out;
  int          exp_f;
  always @(negedge clk) begin
    if (m_started) begin
      for (int i = 0; i < NO; i++) exp_out[i*DW +: DW] = m_out[i];
      exp_f = first_active(m_pend, irq_mask);
      chk("m_read_data",   read_data,   m_rd);
      chk("m_rd_valid",    rd_valid,    m_rdv);
      chk("m_out_ports",   out_ports,   exp_out);
      chk("m_out_strobe",  out_strobe,  m_strobe);
      chk("m_port_err",    port_err,    m_err);
      chk("m_io_busy",     io_busy,     m_busy);
      chk("m_io_ready",    io_ready,    !m_busy);
      chk("m_irq_pending", irq_pending, m_pend);
      chk("m_intr_signal", intr_signal, exp_f >= 0);
      chk("m_intr_id",     intr_id,     (exp_f >= 0) ? exp_f : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; io_read = 0; io_write = 0; port_sel = 0; write_data = 0;
    in_ports = 0; intr_in = 0; irq_mask = 0; intr_ack = 0;
    tick(); tick();
    reset = 0;
    chk("rst_ready", io_ready, 1);
    chk("rst_out", out_ports, 0);
    chk("rst_sig", intr_signal, 0);

    in_ports = 32'h00A5_0000; io_read = 1; port_sel = 2;
    tick(); io_read = 0;
    chk("rd_data", read_data, 8'hA5);
    chk("rd_valid_pulse", rd_valid, 1);
    chk("rd_busy", io_busy, 1);
    tick();
    chk("rd_valid_end", rd_valid, 0);
    chk("rd_busy_end", io_busy, 0);
    chk("rd_hold", read_data, 8'hA5);

    io_write = 1; port_sel = 3; write_data = 8'h3C;
    tick(); port_sel = 1; write_data = 8'h55;
    chk("wr_strobe", out_strobe, 4'b1000);
    chk("wr_out", out_ports, 32'h3C00_0000);
    tick(); io_write = 0;
    chk("wr_ignored", out_ports, 32'h3C00_0000);
    chk("wr_ign_strobe", out_strobe, 0);
    chk("wr_ign_ready", io_ready, 1);

    in_ports = 32'h00A5_5A00; io_read = 1; io_write = 1; port_sel = 1; write_data = 8'h77;
    tick(); io_read = 0; io_write = 0;
    chk("rdwr_data", read_data, 8'h5A);
    chk("rdwr_err", port_err, 1);
    chk("rdwr_out", out_ports, 32'h3C00_0000);
    chk("rdwr_strobe", out_strobe, 0);
    tick();

    io_write = 1; port_sel = 7; write_data = 8'hFF;
    tick(); io_write = 0;
    chk("wr_oor_err", port_err, 1);
    chk("wr_oor_strobe", out_strobe, 0);
    chk("wr_oor_out", out_ports, 32'h3C00_0000);
    tick();

    io_read = 1; port_sel = 5;
    tick(); io_read = 0;
    chk("rd_oor_data", read_data, 0);
    chk("rd_oor_valid", rd_valid, 1);
    chk("rd_oor_err", port_err, 1);
    tick();

    in_ports = 32'h00A5_5A11; io_read = 1; port_sel = 0;
    repeat (4) tick();
    io_read = 0;
    chk("b2b_data", read_data, 8'h11);
    tick(); tick();

    intr_in = 4'b1010;
    tick(); tick();
    chk("irq_lat_early", intr_signal, 0);
    tick();
    chk("irq_lat", intr_signal, 1);
    chk("irq_id1", intr_id, 1);
    chk("irq_pend2", irq_pending, 4'b1010);
    intr_ack = 1; tick(); intr_ack = 0;
    chk("irq_id3", intr_id, 3);
    chk("irq_pend1", irq_pending, 4'b1000);
    intr_ack = 1; tick(); intr_ack = 0;
    chk("irq_none", intr_signal, 0);
    chk("irq_pend0", irq_pending, 0);
    repeat (3) tick();
    chk("irq_level_once", irq_pending, 0);
    intr_in = 0;
    repeat (3) tick();

    irq_mask = 4'b0001; intr_in = 4'b0001;
    repeat (3) tick();
    chk("mask_pend", irq_pending, 4'b0001);
    chk("mask_sig", intr_signal, 0);
    irq_mask = 4'b0000;
    #1;
    chk("unmask_sig", intr_signal, 1);
    chk("unmask_id", intr_id, 0);
    intr_ack = 1; tick(); intr_ack = 0; intr_in = 0;
    chk("unmask_ack", irq_pending, 0);
    repeat (3) tick();

    intr_in = 4'b0100;
    repeat (3) tick();
    chk("l2_pend", irq_pending, 4'b0100);
    intr_in = 0;
    repeat (3) tick();
    intr_in = 4'b0100;
    tick(); tick();
    intr_ack = 1; tick(); intr_ack = 0;
    chk("ack_set_race", irq_pending, 4'b0100);
    chk("ack_set_id", intr_id, 2);
    intr_ack = 1; tick(); intr_ack = 0; intr_in = 0;
    chk("l2_cleared", irq_pending, 0);
    tick();

    intr_in = 4'b0001;
    io_write = 1; port_sel = 0; write_data = 8'h99;
    tick();
    chk("rstb_busy", io_busy, 1);
    chk("rstb_strobe", out_strobe, 4'b0001);
    reset = 1;
    tick();
    chk("rsta_busy", io_busy, 0);
    chk("rsta_ready", io_ready, 1);
    chk("rsta_strobe", out_strobe, 0);
    chk("rsta_out", out_ports, 0);
    chk("rsta_rd", read_data, 0);
    chk("rsta_pend", irq_pending, 0);
    reset = 0; io_write = 0; intr_in = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
